// File: rtl/cdc_ctrl_pkg.sv
// Shared state encoding and defaults for the req/ack CDC source controller.
package cdc_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } state_e;

   localparam int DEF_SYNC_STAGES    = 2;
   localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/cdc_sync_nff.sv
// N-flop single-bit synchronizer with asynchronous active-high reset.
module cdc_sync_nff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_chain <= '0;
      else     r_chain <= {r_chain[STAGES-2:0], i_d};
   end

   assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/cdc_req_ack_tx.sv
// Source-side 4-phase req/ack CDC controller for one data word.
// Optional per-phase watchdog enabled by defining CDC_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a word; in_ready while synced ack is low
// REQ   | xfer_req high, waiting for synced ack to rise
// DROP  | xfer_req low, waiting for synced ack to fall
module cdc_req_ack_tx
   import cdc_ctrl_pkg::*;
#(
   parameter int DATA_W         = 8,
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              xfer_req,
   output logic [DATA_W-1:0] xfer_data,
   input  logic              xfer_ack_async,
   output logic              busy,
   output logic              done,
   output logic              timeout_err
);

   if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("SYNC_STAGES must be at least 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_chk_tmo
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_e              r_state;
   state_e              w_state_nxt;
   logic                w_ack_sync;
   logic                w_accept;
   logic                w_tmo;
   logic                w_req_nxt;
   logic                w_done_nxt;
   logic                w_terr_nxt;
   logic                r_req;
   logic [DATA_W-1:0]   r_data;
   logic                r_done;
   logic                r_terr;

   cdc_sync_nff #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk (clk),
      .rst (rst),
      .i_d (xfer_ack_async),
      .o_q (w_ack_sync)
   );

   // A stale ack still high from the previous handshake blocks acceptance.
   assign in_ready = (r_state == ST_IDLE) && !w_ack_sync;
   assign w_accept = in_valid && in_ready;

`ifdef CDC_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_cnt;

   // Exit fires on the edge that would bring the count to TIMEOUT_CYCLES.
   assign w_tmo = (r_state != ST_IDLE) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         r_cnt <= '0;
      else if (w_state_nxt != r_state) r_cnt <= '0;
      else if (r_state != ST_IDLE)     r_cnt <= r_cnt + 1'b1;
   end
`else
   assign w_tmo = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)    w_state_nxt = ST_REQ;
         ST_REQ:  if (w_ack_sync)  w_state_nxt = ST_DROP;
         ST_DROP: if (!w_ack_sync) w_state_nxt = ST_IDLE;
         default:                  w_state_nxt = ST_IDLE;
      endcase
      if (w_tmo) w_state_nxt = ST_IDLE;
   end

   always_comb begin
      busy       = (r_state != ST_IDLE);
      w_req_nxt  = (w_state_nxt == ST_REQ);
      w_done_nxt = (r_state == ST_DROP) && (w_state_nxt == ST_IDLE) && !w_tmo;
      w_terr_nxt = w_tmo;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req  <= 1'b0;
         r_data <= '0;
         r_done <= 1'b0;
         r_terr <= 1'b0;
      end else begin
         r_req  <= w_req_nxt;
         r_done <= w_done_nxt;
         r_terr <= w_terr_nxt;
         if (w_accept) r_data <= in_data;
      end
   end

   assign xfer_req    = r_req;
   assign xfer_data   = r_data;
   assign done        = r_done;
   assign timeout_err = r_terr;

endmodule
